// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port priority arbiter in front of the SDRAM controller
module sdram_port_arbiter #(
  parameter int ADDR_BITS    = 32,
  parameter int MAX_A_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  // port A: SPI flash emulator, high priority
  input  logic                 a_enable,
  input  logic                 a_we,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [15:0]          a_wr_data,
  input  logic [1:0]           a_wr_mask,
  output logic [15:0]          a_rd_data,
  output logic                 a_ack,
  // port B: user command parser, bulk traffic
  input  logic                 b_enable,
  input  logic                 b_we,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic [15:0]          b_wr_data,
  input  logic [1:0]           b_wr_mask,
  output logic [15:0]          b_rd_data,
  output logic                 b_ack,
  // shared SDRAM controller port
  output logic [ADDR_BITS-1:0] sd_addr,
  output logic [15:0]          sd_wr_data,
  output logic [1:0]           sd_wr_mask,
  output logic                 sd_we,
  output logic                 sd_enable,
  input  logic [15:0]          sd_rd_data,
  input  logic                 sd_ack,
  input  logic                 sd_idle,
  // status
  output logic [1:0]           grant,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_A  = 2'd1,
    BUSY_B  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] STREAK_MAX = 8'(MAX_A_STREAK);

  state_t     state;
  logic [7:0] streak;
  logic       b_wins;
  logic [7:0] streak_inc;

  // B wins when A is absent, or when A has starved a waiting B long enough
  assign b_wins     = b_enable && (!a_enable || (streak >= STREAK_MAX));
  assign streak_inc = (streak >= STREAK_MAX) ? STREAK_MAX : streak + 8'd1;

  // Arbitration FSM: grant in IDLE, forward ack in BUSY_x, one-cycle RELEASE gap
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      streak     <= 8'd0;
      sd_enable  <= 1'b0;
      sd_we      <= 1'b0;
      sd_addr    <= '0;
      sd_wr_data <= 16'd0;
      sd_wr_mask <= 2'b00;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_rd_data  <= 16'd0;
      b_rd_data  <= 16'd0;
      grant      <= 2'b00;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sd_idle && (a_enable || b_enable)) begin
            sd_enable <= 1'b1;
            busy      <= 1'b1;
            if (b_wins) begin
              sd_addr    <= b_addr;
              sd_we      <= b_we;
              sd_wr_data <= b_wr_data;
              sd_wr_mask <= b_wr_mask;
              grant      <= 2'b10;
              streak     <= 8'd0;
              state      <= BUSY_B;
            end else begin
              sd_addr    <= a_addr;
              sd_we      <= a_we;
              sd_wr_data <= a_wr_data;
              sd_wr_mask <= a_wr_mask;
              grant      <= 2'b01;
              // only consecutive A wins over a waiting B count toward starvation
              streak     <= b_enable ? streak_inc : 8'd0;
              state      <= BUSY_A;
            end
          end
        end
        BUSY_A: begin
          if (sd_ack) begin
            sd_enable <= 1'b0;
            sd_we     <= 1'b0;
            a_rd_data <= sd_rd_data;
            a_ack     <= 1'b1;
            state     <= RELEASE;
          end
        end
        BUSY_B: begin
          if (sd_ack) begin
            sd_enable <= 1'b0;
            sd_we     <= 1'b0;
            b_rd_data <= sd_rd_data;
            b_ack     <= 1'b1;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          // gives the served requester one edge to drop enable before re-arbitration
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          grant <= 2'b00;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed table-driven bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_enable, a_we, b_enable, b_we;
  logic [31:0] a_addr, b_addr;
  logic [15:0] a_wr_data, b_wr_data, a_rd_data, b_rd_data;
  logic [1:0]  a_wr_mask, b_wr_mask;
  logic        a_ack, b_ack;
  logic [31:0] sd_addr;
  logic [15:0] sd_wr_data, sd_rd_data;
  logic [1:0]  sd_wr_mask;
  logic        sd_we, sd_enable, sd_ack, sd_idle;
  logic [1:0]  grant;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.ADDR_BITS(32), .MAX_A_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .a_enable(a_enable), .a_we(a_we), .a_addr(a_addr), .a_wr_data(a_wr_data),
    .a_wr_mask(a_wr_mask), .a_rd_data(a_rd_data), .a_ack(a_ack),
    .b_enable(b_enable), .b_we(b_we), .b_addr(b_addr), .b_wr_data(b_wr_data),
    .b_wr_mask(b_wr_mask), .b_rd_data(b_rd_data), .b_ack(b_ack),
    .sd_addr(sd_addr), .sd_wr_data(sd_wr_data), .sd_wr_mask(sd_wr_mask),
    .sd_we(sd_we), .sd_enable(sd_enable), .sd_rd_data(sd_rd_data),
    .sd_ack(sd_ack), .sd_idle(sd_idle), .grant(grant), .busy(busy)
  );

  typedef struct {
    logic        a_en;
    logic        a_we;
    logic [31:0] a_addr;
    logic        b_en;
    logic        b_we;
    logic [31:0] b_addr;
    logic [15:0] b_wd;
    logic [1:0]  b_wm;
    logic        idle;
    logic        ack;
    logic [15:0] rd;
    logic        e_en;
    logic        e_we;
    logic [1:0]  e_grant;
    logic        e_busy;
    logic        e_aack;
    logic        e_back;
    logic [31:0] e_addr;
    logic [15:0] e_wd;
    logic [1:0]  e_wm;
    logic [15:0] e_ard;
    logic [15:0] e_brd;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_order [10];
    logic       seen;
    vec_t       v;

    exp_order = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

    // spurious sd_ack in IDLE, then idle cycle
    vecs.push_back('{1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0,16'h0,2'b00, 1'b1,1'b1,16'h1111,
                     1'b0,1'b0,2'b00,1'b0,1'b0,1'b0, 32'h0,16'h0,2'b00,16'h0,16'h0});
    vecs.push_back('{1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0,16'h0,2'b00, 1'b1,1'b0,16'h1111,
                     1'b0,1'b0,2'b00,1'b0,1'b0,1'b0, 32'h0,16'h0,2'b00,16'h0,16'h0});
    // A-only read: grant then 4 wait cycles, ack on the 5th cycle after sd_enable
    for (int i = 0; i < 5; i++)
      vecs.push_back('{1'b1,1'b0,32'h1234, 1'b0,1'b0,32'h0,16'h0,2'b00, 1'b1,1'b0,16'h0,
                       1'b1,1'b0,2'b01,1'b1,1'b0,1'b0, 32'h1234,16'h5555,2'b11,16'h0,16'h0});
    vecs.push_back('{1'b1,1'b0,32'h1234, 1'b0,1'b0,32'h0,16'h0,2'b00, 1'b1,1'b1,16'hBEEF,
                     1'b0,1'b0,2'b01,1'b1,1'b1,1'b0, 32'h1234,16'h5555,2'b11,16'hBEEF,16'h0});
    vecs.push_back('{1'b0,1'b0,32'h1234, 1'b0,1'b0,32'h0,16'h0,2'b00, 1'b1,1'b0,16'h0,
                     1'b0,1'b0,2'b00,1'b0,1'b0,1'b0, 32'h1234,16'h5555,2'b11,16'hBEEF,16'h0});
    // B-only write
    for (int i = 0; i < 2; i++)
      vecs.push_back('{1'b0,1'b0,32'h0, 1'b1,1'b1,32'h10,16'h00AA,2'b01, 1'b1,1'b0,16'h0,
                       1'b1,1'b1,2'b10,1'b1,1'b0,1'b0, 32'h10,16'h00AA,2'b01,16'hBEEF,16'h0});
    vecs.push_back('{1'b0,1'b0,32'h0, 1'b1,1'b1,32'h10,16'h00AA,2'b01, 1'b1,1'b1,16'hCAFE,
                     1'b0,1'b0,2'b10,1'b1,1'b0,1'b1, 32'h10,16'h00AA,2'b01,16'hBEEF,16'hCAFE});
    vecs.push_back('{1'b0,1'b0,32'h0, 1'b0,1'b1,32'h10,16'h00AA,2'b01, 1'b1,1'b0,16'h0,
                     1'b0,1'b0,2'b00,1'b0,1'b0,1'b0, 32'h10,16'h00AA,2'b01,16'hBEEF,16'hCAFE});

    // reset
    reset = 1'b1;
    a_enable = 1'b0; a_we = 1'b0; a_addr = 32'h0; a_wr_data = 16'h5555; a_wr_mask = 2'b11;
    b_enable = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_wr_data = 16'h0; b_wr_mask = 2'b00;
    sd_rd_data = 16'h0; sd_ack = 1'b0; sd_idle = 1'b1;
    tick(); tick(); tick();
    check("reset_state",
          {sd_enable, sd_we, sd_addr, sd_wr_data, sd_wr_mask, a_ack, b_ack, a_rd_data, b_rd_data, grant, busy},
          {1'b0, 1'b0, 32'h0, 16'h0, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0});
    reset = 1'b0;

    // table-driven single-port sequences
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      a_enable = v.a_en; a_we = v.a_we; a_addr = v.a_addr;
      b_enable = v.b_en; b_we = v.b_we; b_addr = v.b_addr; b_wr_data = v.b_wd; b_wr_mask = v.b_wm;
      sd_idle = v.idle; sd_ack = v.ack; sd_rd_data = v.rd;
      tick();
      check($sformatf("vec%0d", i),
            {sd_enable, sd_we, grant, busy, a_ack, b_ack, sd_addr, sd_wr_data, sd_wr_mask, a_rd_data, b_rd_data},
            {v.e_en, v.e_we, v.e_grant, v.e_busy, v.e_aack, v.e_back, v.e_addr, v.e_wd, v.e_wm, v.e_ard, v.e_brd});
    end
    sd_ack = 1'b0;

    // sd_idle low holds off the request
    a_enable = 1'b1; a_we = 1'b0; a_addr = 32'h40; sd_idle = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("idle_hold%0d", i), {sd_enable, busy}, 2'b00);
    end
    sd_idle = 1'b1;
    tick();
    check("idle_release_grant", {sd_enable, grant, sd_addr}, {1'b1, 2'b01, 32'h40});
    sd_ack = 1'b1; sd_rd_data = 16'h4040;
    tick();
    sd_ack = 1'b0;
    check("idle_release_ack", {a_ack, a_rd_data}, {1'b1, 16'h4040});
    a_enable = 1'b0;
    tick();

    // contention with streak limit 4
    a_enable = 1'b1; a_addr = 32'h100;
    b_enable = 1'b1; b_we = 1'b0; b_addr = 32'h200;
    for (int g = 0; g < 10; g++) begin
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        tick();
        seen = sd_enable;
      end
      if (!seen) begin
        n_checks++; n_fail++;
        $display("FAIL contention_timeout%0d: got no sd_enable expected grant", g);
        break;
      end
      check($sformatf("contention_grant%0d", g), grant, exp_order[g]);
      sd_ack = 1'b1; sd_rd_data = 16'(g + 16'h0A00);
      tick();
      sd_ack = 1'b0;
      if (exp_order[g] == 2'b01) begin
        check($sformatf("contention_ack%0d", g), {a_ack, b_ack, a_rd_data}, {1'b1, 1'b0, 16'(g + 16'h0A00)});
        a_enable = 1'b0; tick(); a_enable = 1'b1;
      end else begin
        check($sformatf("contention_ack%0d", g), {a_ack, b_ack, b_rd_data}, {1'b0, 1'b1, 16'(g + 16'h0A00)});
        b_enable = 1'b0; tick(); b_enable = 1'b1;
      end
    end
    a_enable = 1'b0; b_enable = 1'b0;
    tick(); tick();

    // reset during BUSY_B
    b_enable = 1'b1; b_we = 1'b1; b_addr = 32'h300; b_wr_data = 16'h3333;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      seen = sd_enable;
    end
    check("abort_granted", {seen, grant}, {1'b1, 2'b10});
    tick(); tick();
    reset = 1'b1; b_enable = 1'b0;
    tick();
    check("abort_reset", {sd_enable, grant, busy, b_ack}, {1'b0, 2'b00, 1'b0, 1'b0});
    reset = 1'b0;
    tick();
    sd_ack = 1'b1; sd_rd_data = 16'hDEAD;
    tick();
    sd_ack = 1'b0;
    check("abort_late_ack", {a_ack, b_ack, busy, sd_enable, b_rd_data}, {1'b0, 1'b0, 1'b0, 1'b0, 16'h0});
    tick();
    check("abort_quiet", {a_ack, b_ack, busy, grant}, {1'b0, 1'b0, 1'b0, 2'b00});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
